// File: rtl/riscv_pkg.sv
// Shared RISC-V store-path definitions: store opcode, store size encodings
// and the store-sequencer state encoding.
package riscv_pkg;

  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010,
    F3_SD = 3'b011
  } funct3_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_MERGE,
    S_WRITE,
    S_FIN
  } state_e;

endpackage

// File: rtl/store_lane_merge.sv
// Combinational byte-lane merge: places the low bytes of rs2 at the addressed
// offset inside the old doubleword and keeps every other byte untouched.
module store_lane_merge
  import riscv_pkg::*;
(
  input  funct3_e     funct3,
  input  logic [2:0]  offset,
  input  logic [63:0] rs2_data,
  input  logic [63:0] old_data,
  output logic [63:0] merged
);

  logic [7:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [63:0] bit_mask;
  logic [63:0] shifted;

  always_comb begin
    size_mask = 8'h00;
    bit_mask  = '0;
    case (funct3)
      F3_SB:   size_mask = 8'h01;
      F3_SH:   size_mask = 8'h03;
      F3_SW:   size_mask = 8'h0F;
      F3_SD:   size_mask = 8'hFF;
      default: size_mask = 8'h00;
    endcase
    lane_mask = size_mask << offset;
    for (int i = 0; i < 8; i++) begin
      bit_mask[i*8 +: 8] = {8{lane_mask[i]}};
    end
    shifted = rs2_data << {offset, 3'b000};
    merged  = (old_data & ~bit_mask) | (shifted & bit_mask);
  end

endmodule

// File: rtl/store_merger.sv
// Store sequencer for the multicycle datapath: sd writes directly, narrower
// stores do read-modify-write on the aligned doubleword.
module store_merger
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       instrucao,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       rs2_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                store_q, store_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [63:0]         rs2_q, rs2_d;
  logic [63:0]         old_q, old_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mis_q, mis_d;
  logic                tmo_q, tmo_d;

  logic                legal;
  logic                misal;
  logic                cnt_expired;
  logic [63:0]         merged;
  logic                unused_instr;

  assign unused_instr = ^{instrucao[31:15], instrucao[11:7]};

  store_lane_merge u_merge (
    .funct3   (funct3_e'(funct3_q)),
    .offset   (addr_q[2:0]),
    .rs2_data (rs2_q),
    .old_data (old_q),
    .merged   (merged)
  );

  assign legal       = store_q && !funct3_q[2];
  assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    misal = 1'b0;
    case (funct3_q)
      F3_SH:   misal = addr_q[0];
      F3_SW:   misal = |addr_q[1:0];
      F3_SD:   misal = |addr_q[2:0];
      default: misal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    store_d  = store_q;
    addr_d   = addr_q;
    rs2_d    = rs2_q;
    old_d    = old_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    mis_d    = mis_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_IDLE: begin
        mis_d = 1'b0;
        tmo_d = 1'b0;
        if (start) begin
          funct3_d = instrucao[14:12];
          store_d  = (instrucao[6:0] == OPC_STORE);
          addr_d   = addr;
          rs2_d    = rs2_data;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (!legal) begin
          state_d = S_FIN;
        end else if (misal) begin
          mis_d   = 1'b1;
          state_d = S_FIN;
        end else if (funct3_q == F3_SD) begin
          wdata_d = rs2_q;
          state_d = S_WRITE;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (mem_ready) begin
          old_d   = mem_rdata;
          state_d = S_MERGE;
        end else if (cnt_expired) begin
          tmo_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_MERGE: begin
        wdata_d = merged;
        cnt_d   = '0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (mem_ready) begin
          state_d = S_FIN;
        end else if (cnt_expired) begin
          tmo_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIN: begin
        mis_d   = 1'b0;
        tmo_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request strobes decode straight from state so reset drops them at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      store_q  <= 1'b0;
      addr_q   <= '0;
      rs2_q    <= '0;
      old_q    <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      mis_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      store_q  <= store_d;
      addr_q   <= addr_d;
      rs2_q    <= rs2_d;
      old_q    <= old_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      mis_q    <= mis_d;
      tmo_q    <= tmo_d;
    end
  end

  assign mem_addr    = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem_rd      = (state_q == S_READ);
  assign mem_wr      = (state_q == S_WRITE);
  assign mem_wdata   = wdata_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign misaligned  = done && mis_q;
  assign timeout_err = done && tmo_q;

endmodule

// File: tb/tb_store_merger.sv
// Scoreboard bench for store_merger with a behavioural 64-bit memory that can
// stall or withhold its acknowledge.
module tb_store_merger;

  localparam int AW  = 64;
  localparam int TMO = 255;
  localparam logic [6:0] OPC_ST = 7'b0100011;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   instrucao = '0;
  logic [AW-1:0] addr = '0;
  logic [63:0]   rs2_data = '0;
  logic [63:0]   mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr, busy, done, misaligned, timeout_err;
  logic [63:0]   mem_wdata;

  typedef struct { logic [63:0] a; logic [63:0] d; } wr_t;
  typedef struct { logic mis; logic tmo; } dn_t;

  wr_t         exp_wr[$];
  dn_t         exp_dn[$];
  logic [63:0] mem [logic [63:0]];

  int          n_vec = 0, n_err = 0;
  int          cyc = 0, done_cnt = 0, done_cyc = 0;
  int          rd_cycles = 0, wr_cycles = 0, stall = 0;
  bit          ready_en = 1'b1, block_wr = 1'b0;
  logic [63:0] cur_addr = '0;

  store_merger #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .instrucao(instrucao),
    .addr(addr), .rs2_data(rs2_data), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .misaligned(misaligned),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_merge(logic [63:0] old, logic [63:0] d, int off, int nb);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < nb; b++)
      if (off + b < 8) r[(off + b) * 8 +: 8] = d[b * 8 +: 8];
    return r;
  endfunction

  // Memory responder and output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    wr_t e;
    dn_t f;
    if ((mem_rd || mem_wr) && stall > 0) begin
      mem_ready = 1'b0;
      stall--;
    end else begin
      mem_ready = ready_en && !(mem_wr && block_wr);
    end
    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 64'h0;
    if (busy) begin
      chk("addr_hold", mem_addr, cur_addr);
      chk("rd_wr_excl", mem_rd & mem_wr, 0);
    end
    if (mem_rd) rd_cycles++;
    if (mem_wr) wr_cycles++;
    if (mem_wr && mem_ready) begin
      if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = exp_wr.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_wdata, e.d);
        mem[e.a] = e.d;
      end
    end
    if (done) begin
      if (exp_dn.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        f = exp_dn.pop_front();
        chk("misaligned", misaligned, f.mis);
        chk("timeout_err", timeout_err, f.tmo);
      end
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic run_store(input logic [6:0] opc, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] d, input int stall_n, input bit tmo, input bit poke);
    bit legal, mis;
    int nb, off, exp_lat, target, t0;
    logic [63:0] al, old;
    legal = (opc == OPC_ST) && (f3 < 3'd4);
    nb    = legal ? (1 << f3) : 1;
    off   = int'(a[2:0]);
    mis   = legal && ((off % nb) != 0);
    al    = {a[63:3], 3'b000};
    if (!legal || mis) exp_lat = 2;
    else if (tmo)      exp_lat = TMO + 2;
    else               exp_lat = ((f3 == 3'd3) ? 3 : 5) + stall_n;
    exp_dn.push_back('{mis, tmo && legal && !mis});
    if (legal && !mis && !tmo) begin
      old = mem.exists(al) ? mem[al] : 64'h0;
      exp_wr.push_back('{al, ref_merge(old, d, off, nb)});
    end
    @(posedge clk); #1;
    stall = stall_n; cur_addr = al;
    instrucao = {17'h0, f3, 5'h0, opc}; addr = a; rs2_data = d; start = 1'b1;
    t0 = cyc; rd_cycles = 0; wr_cycles = 0; target = done_cnt + 1;
    @(posedge clk); #1;
    start = 1'b0; addr = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
    if (poke) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < TMO + 50 && done_cnt < target; i++) @(posedge clk);
    chk("done_seen", done_cnt >= target, 1);
    if (done_cnt >= target) chk("latency", done_cyc - t0, exp_lat);
    if (!legal || mis) begin
      chk("no_rd", rd_cycles, 0);
      chk("no_wr", wr_cycles, 0);
    end else if (f3 == 3'd3) begin
      chk("sd_no_rd", rd_cycles, 0);
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("flags_clr", {misaligned, timeout_err}, 0);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [63:0] ra;
    mem[64'h1000] = 64'h1122334455667788;
    mem[64'h4000] = 64'h0F1E2D3C4B5A6978;
    for (int i = 0; i < 4; i++) mem[64'h5000 + 8 * i] = {$urandom, $urandom};

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdwr", {mem_rd, mem_wr}, 0);
    chk("rst_flags", {misaligned, timeout_err}, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_addr", mem_addr, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    run_store(OPC_ST, 3'd0, 64'h1005, 64'hAB, 0, 0, 0);
    run_store(OPC_ST, 3'd1, 64'h2002, 64'hFFFF_BEEF, 0, 0, 0);
    run_store(OPC_ST, 3'd3, 64'h3000, 64'hDEADBEEFCAFEF00D, 0, 0, 0);
    run_store(OPC_ST, 3'd2, 64'h4006, 64'h12345678, 0, 0, 0);
    run_store(OPC_ST, 3'd2, 64'h4004, 64'h12345678, 0, 0, 0);
    run_store(OPC_ST, 3'd1, 64'h2003, 64'h1111, 0, 0, 0);
    run_store(OPC_ST, 3'd3, 64'h3004, 64'h2222, 0, 0, 0);
    run_store(OPC_ST, 3'd0, 64'h1007, 64'hCD, 3, 0, 0);
    run_store(OPC_ST, 3'd1, 64'h1006, 64'h9876, 0, 0, 1);
    run_store(7'b0000011, 3'd0, 64'h1000, 64'h55, 0, 0, 0);
    run_store(OPC_ST, 3'd4, 64'h1000, 64'h55, 0, 0, 0);
    run_store(OPC_ST, 3'd3, 64'h3008, 64'h0123456789ABCDEF, 2, 0, 0);

    for (int i = 0; i < 10; i++) begin
      rf3 = 3'($urandom_range(0, 3));
      ra  = 64'h5000 + 64'(8 * $urandom_range(0, 3)) + 64'($urandom_range(0, 7));
      run_store(OPC_ST, rf3, ra, {$urandom, $urandom}, $urandom_range(0, 2), 0, 0);
    end

    ready_en = 1'b0;
    run_store(OPC_ST, 3'd0, 64'h7001, 64'h77, 0, 1, 0);
    ready_en = 1'b1;

    mem[64'h6000] = 64'h0102030405060708;
    block_wr = 1'b1;
    @(posedge clk); #1;
    cur_addr = 64'h6000; instrucao = {17'h0, 3'd0, 5'h0, OPC_ST};
    addr = 64'h6003; rs2_data = 64'h5A; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 20 && !mem_wr; i++) @(negedge clk);
    chk("wr_reached", mem_wr, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_drop_wr", mem_wr, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    block_wr = 1'b0; reset_n = 1'b1;
    #1 chk("post_rst_busy", busy, 0);
    run_store(OPC_ST, 3'd0, 64'h6003, 64'h5A, 0, 0, 0);

    chk("wr_q_empty", exp_wr.size(), 0);
    chk("dn_q_empty", exp_dn.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/store_merger.md
Name: store_merger

Overview:
Store-side counterpart of the load extender in the multicycle RISC-V datapath. Executes sb/sh/sw/sd against the 64-bit data memory and sequences a read-modify-write for sub-doubleword stores. It merges rs2 bytes into the existing doubleword at the addressed byte offset, and it signals completion or misalignment to the control unit.

Parameters:
- ADDR_W, 64, width of the byte address from the ALU result.
- TIMEOUT, 255, maximum cycles to wait for mem_ready in either access state before aborting.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request from the control unit; sampled only in IDLE.
- instrucao  in  32  current instruction; opcode [6:0] and funct3 [14:12] are used.
- addr  in  ADDR_W  effective byte address.
- rs2_data  in  64  store source register.
- mem_addr  out  ADDR_W  doubleword-aligned address, {addr[ADDR_W-1:3],3'b000}.
- mem_rd  out  1  read request, held until mem_ready.
- mem_wr  out  1  write request, held until mem_ready.
- mem_wdata  out  64  merged doubleword.
- mem_rdata  in  64  read data, valid when mem_rd && mem_ready.
- mem_ready  in  1  memory acknowledge.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  qualifies done: the store was rejected for misalignment.
- timeout_err  out  1  qualifies done: memory never acknowledged.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, every output 0, and internal registers cleared. A reset during READ or WRITE drops mem_rd/mem_wr immediately with no pending write completed.
- On start in IDLE: capture instrucao[14:12], addr, and rs2_data. While busy, start is ignored and the captured values stay stable.
- Store opcode is 7'b0100011. funct3 selects size: 000 sb, 001 sh, 010 sw, 011 sd.
- Non-store opcode or funct3 outside 000..011: go to FIN with no memory access and no error flags.
- Alignment check uses the captured addr: sh needs addr[0]=0, sw needs addr[1:0]=0, sd needs addr[2:0]=0, sb always passes. On failure go to FIN with misaligned=1 and no memory access.
- Byte lane mask: size mask (0x01, 0x03, 0x0F, 0xFF) shifted left by addr[2:0]. Expand each mask bit to a byte to form bitmask M.
- Shifted data: S = rs2_data << (8*addr[2:0]), truncated to 64 bits.
- FSM states and transitions:
  - IDLE: start goes to CHECK.
  - CHECK (1 cycle): illegal or misaligned goes to FIN; sd goes to WRITE with mem_wdata=rs2_data (no read); otherwise goes to READ.
  - READ: mem_rd=1. When mem_ready, latch old=mem_rdata and go to MERGE.
  - MERGE (1 cycle): wdata_reg = (old & ~M) | (S & M). Go to WRITE.
  - WRITE: mem_wr=1, mem_wdata=wdata_reg. When mem_ready, go to FIN.
  - FIN: done=1 for exactly one cycle, with flags valid the same cycle. Go to IDLE; flags clear on the next cycle.
- Latency with zero-wait memory (mem_ready already high): sb/sh/sw take 5 cycles from start to done (CHECK, READ, MERGE, WRITE, FIN). sd takes 3 cycles.
- mem_rd and mem_wr are never high in the same cycle. mem_addr is held constant from CHECK through FIN.
- Timeout: a counter starts on entry to READ or WRITE and increments each cycle without mem_ready. On reaching TIMEOUT, drop the request and go to FIN with timeout_err=1. No write is considered done.
- A start in the same cycle as done is ignored, because the FSM is still in FIN.

Decomposition:
- Shared package (riscv_pkg): the OPC_STORE constant, a funct3 enum (SB/SH/SW/SD), and the state enum.
- One natural sub-module, store_lane_merge: combinational mask, shift, and merge from (funct3, offset, rs2_data, old). It is reused by the FSM in MERGE.

Test Plan:
- sb at addr 0x1005, rs2=0xAB, memory 0x1000 holds 0x1122334455667788 -> read then write 0x1122AB4455667788; done after 5 cycles with zero wait.
- sh at addr 0x2002, rs2=0xFFFF_BEEF, old=0 -> mem_wdata=0x00000000BEEF0000.
- sd at addr 0x3000, rs2=0xDEADBEEFCAFEF00D -> no mem_rd asserted; single write of 0xDEADBEEFCAFEF00D; done 3 cycles after start.
- sw at addr 0x4006 -> done with misaligned=1; mem_rd and mem_wr never asserted.
- Hold mem_ready low for 3 cycles in READ -> mem_rd held, mem_addr stable, merge correct afterwards. Hold it low for TIMEOUT cycles instead -> done with timeout_err=1.
- Assert reset_n low mid-WRITE -> mem_wr falls without waiting for a clock edge; after release busy=0 and the next sb completes normally.
